// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of requester-side and memory-side signals of
// the shared memory port arbiter.
//   slave  : the arbiter's view (requests/memory responses in, grants/beats out)
//   master : the surrounding pipeline / memory view (the opposite directions)
// Handshake: a beat moves from requester i to memory in a cycle where
// mem_req and mem_ack are both high; req_accept[i] marks that same cycle.
// Read data returns in order on mem_rvalid and is routed on rsp_valid.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 14
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*32-1:0]     req_wdata;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        req_accept;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [31:0]               rsp_data;
  logic                      mem_req;
  logic                      mem_wr;
  logic [ADDR_W-1:0]         mem_addr;
  logic [31:0]               mem_wdata;
  logic                      mem_ack;
  logic                      mem_rvalid;
  logic [31:0]               mem_rdata;
  logic                      busy;
  logic                      err_unexpected;
  logic                      state_dbg;  // 0 = IDLE, 1 = BUSY

  modport slave (
    input  req_valid, req_lock, req_wr, req_addr, req_wdata,
    input  mem_ack, mem_rvalid, mem_rdata,
    output req_grant, req_accept, rsp_valid, rsp_data,
    output mem_req, mem_wr, mem_addr, mem_wdata,
    output busy, err_unexpected, state_dbg
  );

  modport master (
    output req_valid, req_lock, req_wr, req_addr, req_wdata,
    output mem_ack, mem_rvalid, mem_rdata,
    input  req_grant, req_accept, rsp_valid, rsp_data,
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    input  busy, err_unexpected, state_dbg
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between NUM_REQ
// requesters (0 = template fetch, 1 = window fetch, 2 = result write-back).
// Round-robin grant with burst locking, and an in-order read-tag FIFO that
// steers returning read data to the requester that issued each read.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - mem_port_arbiter_if.slave: requester inputs, grant/accept/response
//          outputs, memory port, busy, sticky err_unexpected, state_dbg
// Handshake (valid/ready): while BUSY, the owner's req_valid drives mem_req
// (unless a read would overflow the tag FIFO); a beat transfers only in a
// cycle with mem_req & mem_ack, and req_accept[owner] is high exactly then.
module mem_port_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 14,
  parameter int MAX_BURST = 16,
  parameter int MAX_OUT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int OWN_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [OWN_W-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  state_t               state, state_d;
  logic [OWN_W-1:0]     owner, owner_d;
  logic [OWN_W-1:0]     rr_ptr, rr_d;
  logic [NUM_REQ-1:0]   grant, grant_d;
  logic [BEAT_W-1:0]    beat_cnt, beat_d;
  logic                 err_q;

  logic [OWN_W-1:0]     tag_mem [MAX_OUT];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;

  logic [OWN_W-1:0]     winner;
  logic                 found;
  int                   idx;

  logic                 cur_valid, cur_lock, cur_wr;
  logic [ADDR_W-1:0]    cur_addr;
  logic [31:0]          cur_wdata;

  logic                 in_busy, fifo_full, fifo_empty, fifo_full_stall;
  logic                 mem_req_w, transfer, push, pop, release_now;

  // Round-robin search: first requester after rr_ptr, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        winner = OWN_W'(idx);
        found  = 1'b1;
      end
    end
  end

  // Owner's request slice.
  always_comb begin
    cur_valid = 1'b0;
    cur_lock  = 1'b0;
    cur_wr    = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OWN_W'(i)) begin
        cur_valid = bus.req_valid[i];
        cur_lock  = bus.req_lock[i];
        cur_wr    = bus.req_wr[i];
        cur_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        cur_wdata = bus.req_wdata[i*32 +: 32];
      end
    end
  end

  assign in_busy    = (state == BUSY);
  assign fifo_full  = (count == CNT_W'(MAX_OUT));
  assign fifo_empty = (count == '0);
  // Only reads need a tag slot; writes go through even with a full FIFO.
  assign fifo_full_stall = fifo_full & ~cur_wr;
  assign mem_req_w  = in_busy & cur_valid & ~fifo_full_stall;
  assign transfer   = mem_req_w & bus.mem_ack;
  // A read transfer implies the FIFO was not full, so a same-cycle pop can
  // never make room for a push that the stall already refused.
  assign push       = transfer & ~cur_wr;
  assign pop        = bus.mem_rvalid & ~fifo_empty;

  assign release_now = (transfer && (!cur_lock || beat_cnt == BEAT_W'(MAX_BURST-1)))
                     || (!cur_valid && !cur_lock);

  // Next-state logic.
  always_comb begin
    state_d = state;
    owner_d = owner;
    grant_d = grant;
    rr_d    = rr_ptr;
    beat_d  = beat_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          owner_d = winner;
          grant_d = onehot(winner);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = owner;
          beat_d  = '0;
        end else if (transfer) begin
          beat_d = beat_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      grant    <= '0;
      rr_ptr   <= OWN_W'(NUM_REQ-1);
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      owner    <= owner_d;
      grant    <= grant_d;
      rr_ptr   <= rr_d;
      beat_cnt <= beat_d;
    end
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.mem_rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= owner;
  end

  assign bus.req_grant      = grant;
  assign bus.req_accept     = transfer ? onehot(owner) : '0;
  assign bus.rsp_valid      = pop ? onehot(tag_mem[rd_ptr]) : '0;
  assign bus.rsp_data       = bus.mem_rdata;
  assign bus.mem_req        = mem_req_w;
  assign bus.mem_wr         = in_busy & cur_wr;
  assign bus.mem_addr       = in_busy ? cur_addr : '0;
  assign bus.mem_wdata      = in_busy ? cur_wdata : '0;
  assign bus.busy           = in_busy | ~fifo_empty;
  assign bus.err_unexpected = err_q;
  assign bus.state_dbg      = logic'(state);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. Inputs are
// driven 1 time unit after the rising edge, outputs sampled on the falling
// edge. One task per scenario, each with its own inline comparisons.
module tb_mem_port_arbiter;
  localparam int NUM_REQ   = 3;
  localparam int ADDR_W    = 14;
  localparam int MAX_BURST = 16;
  localparam int MAX_OUT   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    bus.req_valid  = '0;
    bus.req_lock   = '0;
    bus.req_wr     = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    sample();
    checks++; if (bus.req_grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", bus.req_grant); end
    checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 14'h0 || bus.mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem: got req=%b addr=%h wr=%b expected 0", bus.mem_req, bus.mem_addr, bus.mem_wr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.err_unexpected !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err_unexpected); end
    checks++; if (bus.req_accept !== 3'b000 || bus.rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_acc_rsp: got acc=%b rsp=%b expected 000", bus.req_accept, bus.rsp_valid); end
    checks++; if (bus.state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", bus.state_dbg); end
  endtask

  task automatic test_single_read;
    apply_reset();
    bus.req_valid = 3'b001;
    bus.req_addr[0 +: ADDR_W] = 14'h0010;
    bus.mem_ack = 1'b1;
    sample();
    checks++; if (bus.req_grant !== 3'b000 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL single_early: got grant=%b req=%b expected 000/0", bus.req_grant, bus.mem_req); end
    step();
    sample();
    checks++; if (bus.req_grant !== 3'b001) begin errors++; $display("FAIL single_grant: got %b expected 001", bus.req_grant); end
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_wr !== 1'b0 || bus.mem_addr !== 14'h0010) begin errors++; $display("FAIL single_mem: got req=%b wr=%b addr=%h expected 1/0/0010", bus.mem_req, bus.mem_wr, bus.mem_addr); end
    checks++; if (bus.req_accept !== 3'b001) begin errors++; $display("FAIL single_accept: got %b expected 001", bus.req_accept); end
    step();
    bus.req_valid = 3'b000;
    sample();
    checks++; if (bus.req_grant !== 3'b000 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_release: got grant=%b busy=%b expected 000/1", bus.req_grant, bus.busy); end
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    sample();
    checks++; if (bus.rsp_valid !== 3'b001 || bus.rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rsp: got rsp=%b data=%h expected 001/deadbeef", bus.rsp_valid, bus.rsp_data); end
    step();
    bus.mem_rvalid = 1'b0;
    sample();
    checks++; if (bus.busy !== 1'b0 || bus.err_unexpected !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b err=%b expected 0/0", bus.busy, bus.err_unexpected); end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_g [8];
    logic [2:0] exp_r [4];
    exp_g = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    exp_r = '{3'b001, 3'b010, 3'b100, 3'b001};
    apply_reset();
    bus.req_valid = 3'b111;
    bus.mem_ack   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      sample();
      checks++; if (bus.req_grant !== exp_g[c] || bus.req_accept !== exp_g[c]) begin errors++; $display("FAIL rr_cycle%0d: got grant=%b acc=%b expected %b", c, bus.req_grant, bus.req_accept, exp_g[c]); end
      step();
    end
    bus.req_valid = 3'b000;
    for (int k = 0; k < 4; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h100 + 32'(k);
      sample();
      checks++; if (bus.rsp_valid !== exp_r[k] || bus.rsp_data !== 32'h100 + 32'(k)) begin errors++; $display("FAIL rr_rsp%0d: got rsp=%b data=%h expected %b/%h", k, bus.rsp_valid, bus.rsp_data, exp_r[k], 32'h100 + 32'(k)); end
      step();
    end
    bus.mem_rvalid = 1'b0;
    sample();
    checks++; if (bus.busy !== 1'b0 || bus.err_unexpected !== 1'b0) begin errors++; $display("FAIL rr_drained: got busy=%b err=%b expected 0/0", bus.busy, bus.err_unexpected); end
  endtask

  task automatic test_burst_lock;
    int acc;
    apply_reset();
    bus.req_wr    = 3'b111;
    bus.mem_ack   = 1'b1;
    bus.req_valid = 3'b010;
    bus.req_lock  = 3'b010;
    step();
    bus.req_valid = 3'b011;
    acc = 0;
    for (int c = 0; c < 16; c++) begin
      sample();
      if (bus.req_accept[1] === 1'b1 && bus.req_grant === 3'b010) acc++;
      step();
    end
    checks++; if (acc !== MAX_BURST) begin errors++; $display("FAIL burst_count: got %0d accepts expected %0d", acc, MAX_BURST); end
    sample();
    checks++; if (bus.req_grant !== 3'b000 || bus.req_accept !== 3'b000) begin errors++; $display("FAIL burst_forced_release: got grant=%b acc=%b expected 000/000", bus.req_grant, bus.req_accept); end
    step();
    sample();
    checks++; if (bus.req_grant !== 3'b001 || bus.req_accept !== 3'b001) begin errors++; $display("FAIL burst_next_owner: got grant=%b acc=%b expected 001/001", bus.req_grant, bus.req_accept); end
    step();
    bus.req_valid = 3'b010;
    sample();
    checks++; if (bus.req_grant !== 3'b000) begin errors++; $display("FAIL burst_bubble: got %b expected 000", bus.req_grant); end
    step();
    sample();
    checks++; if (bus.req_grant !== 3'b010 || bus.req_accept !== 3'b010) begin errors++; $display("FAIL burst_regain: got grant=%b acc=%b expected 010/010", bus.req_grant, bus.req_accept); end
    step();
    bus.req_valid = 3'b000;
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++; if (bus.req_grant !== 3'b010 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL burst_hold%0d: got grant=%b req=%b expected 010/0", c, bus.req_grant, bus.mem_req); end
      step();
    end
    bus.req_lock = 3'b000;
    step();
    sample();
    checks++; if (bus.req_grant !== 3'b000 || bus.state_dbg !== 1'b0) begin errors++; $display("FAIL burst_unlock_release: got grant=%b state=%b expected 000/0", bus.req_grant, bus.state_dbg); end
  endtask

  task automatic test_fifo_full;
    apply_reset();
    bus.req_valid = 3'b001;
    bus.req_lock  = 3'b001;
    bus.mem_ack   = 1'b1;
    step();
    for (int k = 0; k < MAX_OUT; k++) begin
      sample();
      checks++; if (bus.mem_req !== 1'b1 || bus.req_accept !== 3'b001) begin errors++; $display("FAIL full_fill%0d: got req=%b acc=%b expected 1/001", k, bus.mem_req, bus.req_accept); end
      step();
    end
    sample();
    checks++; if (bus.mem_req !== 1'b0 || bus.req_grant !== 3'b001 || bus.req_accept !== 3'b000) begin errors++; $display("FAIL full_stall: got req=%b grant=%b acc=%b expected 0/001/000", bus.mem_req, bus.req_grant, bus.req_accept); end
    step();
    bus.req_wr = 3'b001;
    bus.req_wdata[0 +: 32] = 32'hCAFE0001;
    sample();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_wr !== 1'b1 || bus.req_accept !== 3'b001 || bus.mem_wdata !== 32'hCAFE0001) begin errors++; $display("FAIL full_write: got req=%b wr=%b acc=%b wdata=%h expected 1/1/001/cafe0001", bus.mem_req, bus.mem_wr, bus.req_accept, bus.mem_wdata); end
    step();
    bus.req_wr = 3'b000;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h55;
    sample();
    checks++; if (bus.mem_req !== 1'b0 || bus.rsp_valid !== 3'b001) begin errors++; $display("FAIL full_pop_cycle: got req=%b rsp=%b expected 0/001", bus.mem_req, bus.rsp_valid); end
    step();
    bus.mem_rvalid = 1'b0;
    sample();
    checks++; if (bus.mem_req !== 1'b1 || bus.req_accept !== 3'b001) begin errors++; $display("FAIL full_one_more: got req=%b acc=%b expected 1/001", bus.mem_req, bus.req_accept); end
    step();
    sample();
    checks++; if (bus.mem_req !== 1'b0 || bus.req_grant !== 3'b001) begin errors++; $display("FAIL full_stall_again: got req=%b grant=%b expected 0/001", bus.mem_req, bus.req_grant); end
    bus.req_valid = 3'b000;
    bus.req_lock  = 3'b000;
    step();
    for (int k = 0; k < MAX_OUT; k++) begin
      bus.mem_rvalid = 1'b1;
      sample();
      checks++; if (bus.rsp_valid !== 3'b001) begin errors++; $display("FAIL full_drain%0d: got %b expected 001", k, bus.rsp_valid); end
      step();
    end
    bus.mem_rvalid = 1'b0;
    sample();
    checks++; if (bus.busy !== 1'b0 || bus.err_unexpected !== 1'b0) begin errors++; $display("FAIL full_done: got busy=%b err=%b expected 0/0", bus.busy, bus.err_unexpected); end
  endtask

  task automatic do_read(input int i, input logic [ADDR_W-1:0] addr);
    logic found;
    found = 1'b0;
    bus.req_valid = '0;
    bus.req_valid[i] = 1'b1;
    bus.req_addr[i*ADDR_W +: ADDR_W] = addr;
    bus.mem_ack = 1'b1;
    for (int c = 0; c < 8 && !found; c++) begin
      sample();
      if (bus.req_accept[i] === 1'b1 && bus.mem_addr === addr) found = 1'b1;
      step();
    end
    bus.req_valid = '0;
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL route_issue_req%0d: got no accept expected accept at addr %h", i, addr); end
  endtask

  task automatic test_routing;
    logic [2:0] exp_r [3];
    exp_r = '{3'b100, 3'b001, 3'b100};
    apply_reset();
    do_read(2, 14'h0200);
    do_read(0, 14'h0001);
    do_read(2, 14'h0202);
    for (int k = 0; k < 3; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'(k + 1);
      sample();
      checks++; if (bus.rsp_valid !== exp_r[k] || bus.rsp_data !== 32'(k + 1)) begin errors++; $display("FAIL route_rsp%0d: got rsp=%b data=%h expected %b/%h", k, bus.rsp_valid, bus.rsp_data, exp_r[k], 32'(k + 1)); end
      step();
    end
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_errors;
    apply_reset();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0BAD;
    sample();
    checks++; if (bus.rsp_valid !== 3'b000) begin errors++; $display("FAIL err_no_rsp: got %b expected 000", bus.rsp_valid); end
    step();
    bus.mem_rvalid = 1'b0;
    sample();
    checks++; if (bus.err_unexpected !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", bus.err_unexpected); end
    step();
    sample();
    checks++; if (bus.err_unexpected !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus.err_unexpected); end
    bus.req_valid = 3'b001;
    bus.req_lock  = 3'b001;
    bus.mem_ack   = 1'b1;
    step();
    sample();
    checks++; if (bus.req_accept !== 3'b001) begin errors++; $display("FAIL err_burst_beat0: got %b expected 001", bus.req_accept); end
    step();
    sample();
    checks++; if (bus.req_accept !== 3'b001) begin errors++; $display("FAIL err_burst_beat1: got %b expected 001", bus.req_accept); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    sample();
    checks++; if (bus.req_grant !== 3'b000 || bus.busy !== 1'b0 || bus.err_unexpected !== 1'b0) begin errors++; $display("FAIL err_midreset: got grant=%b busy=%b err=%b expected 000/0/0", bus.req_grant, bus.busy, bus.err_unexpected); end
    step();
    bus.mem_rvalid = 1'b1;
    sample();
    checks++; if (bus.rsp_valid !== 3'b000) begin errors++; $display("FAIL err_late_rsp: got %b expected 000", bus.rsp_valid); end
    step();
    bus.mem_rvalid = 1'b0;
    sample();
    checks++; if (bus.err_unexpected !== 1'b1) begin errors++; $display("FAIL err_late_set: got %b expected 1", bus.err_unexpected); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_lock();
    test_fifo_full();
    test_routing();
    test_errors();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between requesters of the frame-processing pipeline: template fetch (0), window fetch (1), result write-back (2).
- Grants one owner at a time, round-robin, with burst locking so a multi-beat patch fetch is not interleaved.
- Tracks outstanding reads in a tag FIFO and routes read data back to the requester that issued each read.
- Replaces the ad-hoc req/rd_wr/tem_win muxing in the top-level format sequencer.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 is served first after reset.
- ADDR_W, 14, memory word-address width.
- MAX_BURST, 16, maximum accepted beats per grant before forced release.
- MAX_OUT, 4, read-tag FIFO depth (maximum outstanding reads); power of two.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a beat to issue.
- req_lock  in  NUM_REQ  requester i wants to keep its grant after the current beat.
- req_wr  in  NUM_REQ  1 = write, 0 = read, per requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; slice i is requester i.
- req_wdata  in  NUM_REQ*32  packed write data.
- req_grant  out  NUM_REQ  one-hot owner, registered.
- req_accept  out  NUM_REQ  beat of requester i accepted this cycle; combinational.
- rsp_valid  out  NUM_REQ  read data for requester i is on rsp_data.
- rsp_data  out  32  read data, equal to mem_rdata.
- mem_req  out  1  beat request to memory.
- mem_wr  out  1  write enable.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  memory accepts the beat this cycle.
- mem_rvalid  in  1  read data valid, in order.
- mem_rdata  in  32  read data.
- busy  out  1  state is not IDLE, or the tag FIFO is non-empty.
- err_unexpected  out  1  sticky: mem_rvalid arrived while the tag FIFO was empty.

Behaviour:
- Reset: state=IDLE; req_grant=0; rr_ptr=NUM_REQ-1; beat_cnt=0; FIFO empty; err_unexpected=0. All outputs 0; mem_* outputs 0 while not BUSY.
- Reset mid-transfer drops all state. Responses still in flight after reset hit an empty FIFO and set err_unexpected.
- IDLE: if any req_valid is set, the winner is the first set bit searching from rr_ptr+1 modulo NUM_REQ.
  - owner<=winner, req_grant<=onehot(winner), state<=BUSY. Grant appears the cycle after req_valid.
  - No req_valid: stay in IDLE.
- BUSY:
  - mem_req = req_valid[owner] & ~fifo_full_stall.
  - mem_wr, mem_addr, mem_wdata are muxed from the owner's slices.
  - Transfer = mem_req & mem_ack; req_accept[owner] = transfer.
  - fifo_full_stall = FIFO full and the transfer would be a read. Writes are never stalled by the FIFO.
- On a read transfer: push owner id into the tag FIFO. Push is blocked when full, even if a pop happens in the same cycle.
- On a transfer: beat_cnt += 1.
- Release (state<=IDLE, req_grant<=0, rr_ptr<=owner, beat_cnt<=0) when either:
  - (a) transfer and ~req_lock[owner], or
  - (b) transfer and beat_cnt==MAX_BURST-1 (forced release, even if locked), or
  - (c) ~req_valid[owner] and ~req_lock[owner].
- Every release leaves one idle bubble cycle before the next grant.
- A locked owner with req_valid=0 keeps the grant indefinitely.
- mem_rvalid with FIFO non-empty: rsp_valid[head]=1 in the same cycle, rsp_data=mem_rdata, pop the FIFO.
- Pop is independent of state; responses keep draining in IDLE and under other owners.
- mem_rvalid with FIFO empty: all rsp_valid stay 0, err_unexpected<=1. It stays set until rst.
- Simultaneous push and pop with the FIFO not full: both occur and the count is unchanged.
- FIFO pointers wrap modulo MAX_OUT. Count width is clog2(MAX_OUT)+1.

Test Plan:
- Single read: rst, then req_valid=3'b001, addr0=0x0010, mem_ack=1, lock=0.
  - req_grant=001 one cycle later; mem_addr=0x0010 and req_accept[0] on that cycle; grant clears next cycle.
  - mem_rvalid with 0xDEADBEEF two cycles later gives rsp_valid=001 and rsp_data=0xDEADBEEF.
- Round-robin: hold req_valid=3'b111, lock=0, mem_ack=1, rvalid returned every cycle.
  - Grant order 001, 010, 100, 001, with one bubble cycle between grants.
- Burst lock and force: requester 1 with lock=1, valid=1 for 20 beats, requester 0 also valid.
  - Exactly 16 accepts go to requester 1, then release, then requester 0 is granted; requester 1 regains the grant after requester 0 releases.
- FIFO full: MAX_OUT=4, mem_ack=1, mem_rvalid withheld.
  - 4 reads accepted, then mem_req=0 with the grant held. One rvalid allows exactly one more accept.
  - A write from the owner during the full condition is accepted.
- Response routing: interleave reads from requesters 2, 0, 2; return data 1, 2, 3 in order.
  - rsp_valid = 100, 001, 100 with the matching data.
- Errors and reset: mem_rvalid with the FIFO empty sets err_unexpected=1 and no rsp_valid.
  - rst asserted mid-burst (2 reads outstanding) gives grant=0, busy=0, err_unexpected=0 the next cycle.
  - A late rvalid then sets err_unexpected again.
